// File: rtl/operand_ext_unit.sv
// Multi-cycle ARM operand extender/shifter: decodes immediate forms and performs
// LSL/LSR/ASR/ROR with ARM carry-out, STEP bits per cycle behind valid/ready.
module operand_ext_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [7:0]       shamt,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ext_imm,
  output logic             carry_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Count must hold WIDTH+1 and any raw 8-bit shamt.
  localparam int CW = ($clog2(WIDTH + 2) > 8) ? $clog2(WIDTH + 2) : 8;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LSL = 2'd0,
    OP_LSR = 2'd1,
    OP_ASR = 2'd2,
    OP_ROR = 2'd3
  } op_t;

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_init_op;
  logic [WIDTH-1:0] r_work, r_ext, w_init_val, w_sh_val;
  logic [CW-1:0]    r_rem, w_init_eff, w_step_n;
  logic             r_carry, r_cout, w_init_c, w_sh_c;
  logic             w_accept, w_last;
  int               w_eff_i;

  // Handshake: a request is taken on any rising edge with in_valid && in_ready;
  // a result is consumed on any rising edge with out_valid && out_ready. Both
  // ready/valid outputs decode registered state only.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;
  assign ext_imm   = r_ext;
  assign carry_out = r_cout;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Operand, operation and step count decoded from the live request inputs.
  always_comb begin
    w_init_val = rs_val;
    w_init_op  = OP_LSL;
    w_init_c   = carry_in;
    w_eff_i    = 0;
    case (imm_src)
      3'b000: w_init_val = {{(WIDTH-8){1'b0}}, instr[7:0]};
      3'b001: begin
        w_init_val = {{(WIDTH-8){1'b0}}, instr[7:0]};
        w_init_op  = OP_ROR;
        w_eff_i    = 2 * int'(instr[11:8]);
      end
      3'b010: w_init_val = {{(WIDTH-26){instr[23]}}, instr, 2'b00};
      3'b011: w_init_val = {{(WIDTH-12){1'b0}}, instr[11:0]};
      3'b100: begin
        w_init_op = OP_LSL;
        w_eff_i   = (int'(shamt) > WIDTH + 1) ? WIDTH + 1 : int'(shamt);
      end
      3'b101: begin
        w_init_op = OP_LSR;
        w_eff_i   = (int'(shamt) > WIDTH + 1) ? WIDTH + 1 : int'(shamt);
      end
      3'b110: begin
        w_init_op = OP_ASR;
        w_eff_i   = (int'(shamt) > WIDTH) ? WIDTH : int'(shamt);
      end
      default: begin
        w_init_op = OP_ROR;
        w_eff_i   = int'(shamt) % WIDTH;
        // A full-turn rotate leaves the value but still reports its MSB.
        if ((shamt != 8'd0) && (w_eff_i == 0)) w_init_c = rs_val[WIDTH-1];
      end
    endcase
  end

  assign w_init_eff = CW'(w_eff_i);

  assign w_step_n = (r_rem < STEP_C) ? r_rem : STEP_C;
  assign w_last   = (r_rem <= STEP_C);

  // Up to STEP single-bit steps; the carry tracks the last bit pushed out.
  always_comb begin
    w_sh_val = r_work;
    w_sh_c   = r_carry;
    for (int k = 0; k < STEP; k++) begin
      if (CW'(k) < w_step_n) begin
        case (r_op)
          OP_LSL: begin
            w_sh_c   = w_sh_val[WIDTH-1];
            w_sh_val = {w_sh_val[WIDTH-2:0], 1'b0};
          end
          OP_LSR: begin
            w_sh_c   = w_sh_val[0];
            w_sh_val = {1'b0, w_sh_val[WIDTH-1:1]};
          end
          OP_ASR: begin
            w_sh_c   = w_sh_val[0];
            w_sh_val = {w_sh_val[WIDTH-1], w_sh_val[WIDTH-1:1]};
          end
          OP_ROR: begin
            w_sh_c   = w_sh_val[0];
            w_sh_val = {w_sh_val[0], w_sh_val[WIDTH-1:1]};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = (w_init_eff == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers are written only when a result completes, so they hold
  // through backpressure and while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work  <= '0;
      r_rem   <= '0;
      r_op    <= OP_LSL;
      r_carry <= 1'b0;
      r_ext   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_work  <= w_init_val;
      r_rem   <= w_init_eff;
      r_op    <= w_init_op;
      r_carry <= w_init_c;
      if (w_init_eff == '0) begin
        r_ext  <= w_init_val;
        r_cout <= w_init_c;
      end
    end else if (r_state == S_SHIFT) begin
      r_work  <= w_sh_val;
      r_rem   <= r_rem - w_step_n;
      r_carry <= w_sh_c;
      if (w_last) begin
        r_ext  <= w_sh_val;
        r_cout <= w_sh_c;
      end
    end
  end

endmodule

// File: tb/tb_operand_ext_unit.sv
// Bench for operand_ext_unit: directed ARM cases, backpressure, mid-shift reset,
// and random requests against an ARM-rule reference model at STEP = 4, 1 and 32.
module tb_operand_ext_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] instr;
  logic [2:0]  imm_src;
  logic [31:0] rs_val;
  logic [7:0]  shamt;
  logic        carry_in;

  // Index 0: STEP=4, 1: STEP=1, 2: STEP=32
  logic        iv[3];
  logic        ordy[3];
  logic        irdy[3];
  logic        ov[3];
  logic [31:0] ext[3];
  logic        co[3];
  logic        bz[3];
  logic [1:0]  dst[3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  operand_ext_unit #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]),
    .instr(instr), .imm_src(imm_src), .rs_val(rs_val), .shamt(shamt),
    .carry_in(carry_in), .out_valid(ov[0]), .out_ready(ordy[0]),
    .ext_imm(ext[0]), .carry_out(co[0]), .busy(bz[0]), .dbg_state(dst[0]));

  operand_ext_unit #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]),
    .instr(instr), .imm_src(imm_src), .rs_val(rs_val), .shamt(shamt),
    .carry_in(carry_in), .out_valid(ov[1]), .out_ready(ordy[1]),
    .ext_imm(ext[1]), .carry_out(co[1]), .busy(bz[1]), .dbg_state(dst[1]));

  operand_ext_unit #(.WIDTH(32), .STEP(32)) u_s32 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]),
    .instr(instr), .imm_src(imm_src), .rs_val(rs_val), .shamt(shamt),
    .carry_in(carry_in), .out_valid(ov[2]), .out_ready(ordy[2]),
    .ext_imm(ext[2]), .carry_out(co[2]), .busy(bz[2]), .dbg_state(dst[2]));

  function automatic int step_of(input int u);
    case (u)
      0: return 4;
      1: return 1;
      default: return 32;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ARM operand-2 rules written case by case: returns {carry, result}.
  function automatic logic [32:0] ref_model(input logic [2:0] src, input logic [23:0] ins,
                                            input logic [31:0] rs, input logic [7:0] sh,
                                            input logic cin);
    logic [31:0] r;
    logic [31:0] imm8;
    logic        c;
    int          s;
    int          rot;
    s = int'(sh);
    c = cin;
    r = rs;
    imm8 = {24'b0, ins[7:0]};
    case (src)
      3'd0: r = imm8;
      3'd1: begin
        rot = 2 * int'(ins[11:8]);
        r = imm8;
        if (rot != 0) begin
          r = (imm8 >> rot) | (imm8 << (32 - rot));
          c = r[31];
        end
      end
      3'd2: r = {{6{ins[23]}}, ins, 2'b00};
      3'd3: r = {20'b0, ins[11:0]};
      3'd4: if (s > 0) begin
        if (s < 32) begin r = rs << s; c = rs[32-s]; end
        else if (s == 32) begin r = 0; c = rs[0]; end
        else begin r = 0; c = 1'b0; end
      end
      3'd5: if (s > 0) begin
        if (s < 32) begin r = rs >> s; c = rs[s-1]; end
        else if (s == 32) begin r = 0; c = rs[31]; end
        else begin r = 0; c = 1'b0; end
      end
      3'd6: if (s > 0) begin
        if (s < 32) begin r = $signed(rs) >>> s; c = rs[s-1]; end
        else begin r = {32{rs[31]}}; c = rs[31]; end
      end
      default: if (s > 0) begin
        rot = s % 32;
        if (rot == 0) c = rs[31];
        else begin r = (rs >> rot) | (rs << (32 - rot)); c = rs[rot-1]; end
      end
    endcase
    return {c, r};
  endfunction

  function automatic int exp_lat(input logic [2:0] src, input logic [23:0] ins,
                                 input logic [7:0] sh, input int step);
    int s;
    int eff;
    s = int'(sh);
    case (src)
      3'd1: eff = 2 * int'(ins[11:8]);
      3'd4, 3'd5: eff = (s > 33) ? 33 : s;
      3'd6: eff = (s > 32) ? 32 : s;
      3'd7: eff = s % 32;
      default: eff = 0;
    endcase
    return (eff == 0) ? 1 : 1 + (eff + step - 1) / step;
  endfunction

  task automatic run_txn(input int u, input logic [2:0] src, input logic [23:0] ins,
                         input logic [31:0] rs, input logic [7:0] sh, input logic cin,
                         output logic [31:0] res, output logic c, output int lat);
    imm_src = src; instr = ins; rs_val = rs; shamt = sh; carry_in = cin;
    iv[u] = 1'b1;
    @(posedge clk); #1;
    iv[u] = 1'b0;
    lat = 1;
    while (!ov[u] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = ext[u];
    c = co[u];
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
  endtask

  task automatic do_txn(input string tag, input int u, input logic [2:0] src,
                        input logic [23:0] ins, input logic [31:0] rs, input logic [7:0] sh,
                        input logic cin, input logic [31:0] e_res, input logic e_c,
                        input int e_lat);
    logic [31:0] res;
    logic        c;
    int          lat;
    run_txn(u, src, ins, rs, sh, cin, res, c, lat);
    check({tag, ".ext_imm"}, 64'(res), 64'(e_res));
    check({tag, ".carry"}, 64'(c), 64'(e_c));
    check({tag, ".latency"}, 64'(lat), 64'(e_lat));
    check({tag, ".in_ready_after"}, 64'(irdy[u]), 64'd1);
  endtask

  task automatic do_rand(input int u, input int idx);
    logic [2:0]  src;
    logic [23:0] ins;
    logic [31:0] rs;
    logic [7:0]  sh;
    logic        cin;
    logic [32:0] m;
    src = 3'($urandom_range(0, 7));
    ins = 24'($urandom);
    rs  = $urandom;
    cin = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: sh = 8'd0;
      1: sh = 8'd1;
      2: sh = 8'd31;
      3: sh = 8'd32;
      4: sh = 8'd33;
      5: sh = 8'd64;
      default: sh = 8'($urandom_range(0, 255));
    endcase
    m = ref_model(src, ins, rs, sh, cin);
    do_txn($sformatf("rand_u%0d_%0d", u, idx), u, src, ins, rs, sh, cin,
           m[31:0], m[32], exp_lat(src, ins, sh, step_of(u)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_ext;
    logic        held_c;
    reset = 1'b1;
    instr = '0; imm_src = '0; rs_val = '0; shamt = '0; carry_in = 1'b0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_u%0d.in_ready", i), 64'(irdy[i]), 64'd1);
      check($sformatf("reset_u%0d.out_valid", i), 64'(ov[i]), 64'd0);
      check($sformatf("reset_u%0d.ext_imm", i), 64'(ext[i]), 64'd0);
      check($sformatf("reset_u%0d.carry", i), 64'(co[i]), 64'd0);
      check($sformatf("reset_u%0d.busy", i), 64'(bz[i]), 64'd0);
    end

    // Directed immediate and shift cases, STEP = 4
    do_txn("rot_imm_4ff", 0, 3'b001, 24'h0004FF, 32'h0, 8'd0, 1'b0, 32'hFF000000, 1'b1, 3);
    do_txn("rot_imm_0ab", 0, 3'b001, 24'h0000AB, 32'h0, 8'd0, 1'b1, 32'h000000AB, 1'b1, 1);
    do_txn("imm8",        0, 3'b000, 24'h123456, 32'h0, 8'd0, 1'b0, 32'h00000056, 1'b0, 1);
    do_txn("branch_neg",  0, 3'b010, 24'hFFFFFE, 32'h0, 8'd0, 1'b0, 32'hFFFFFFF8, 1'b0, 1);
    do_txn("branch_pos",  0, 3'b010, 24'h000010, 32'h0, 8'd0, 1'b1, 32'h00000040, 1'b1, 1);
    do_txn("imm12",       0, 3'b011, 24'h123456, 32'h0, 8'd0, 1'b1, 32'h00000456, 1'b1, 1);
    do_txn("lsl32",  0, 3'b100, 24'h0, 32'h80000001, 8'd32,  1'b0, 32'h0, 1'b1, 9);
    do_txn("lsl40",  0, 3'b100, 24'h0, 32'h80000001, 8'd40,  1'b1, 32'h0, 1'b0, 10);
    do_txn("lsl0",   0, 3'b100, 24'h0, 32'h80000001, 8'd0,   1'b1, 32'h80000001, 1'b1, 1);
    do_txn("lsr32",  0, 3'b101, 24'h0, 32'h80000001, 8'd32,  1'b0, 32'h0, 1'b1, 9);
    do_txn("asr200", 0, 3'b110, 24'h0, 32'h80000000, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1, 9);
    do_txn("ror36",  0, 3'b111, 24'h0, 32'h12345678, 8'd36,  1'b0, 32'h81234567, 1'b1, 2);
    do_txn("ror64",  0, 3'b111, 24'h0, 32'h12345678, 8'd64,  1'b1, 32'h12345678, 1'b0, 1);
    do_txn("ror0",   0, 3'b111, 24'h0, 32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1, 1);

    // Same LSL cases at STEP = 1 and STEP = 32
    do_txn("s1_lsl32",  1, 3'b100, 24'h0, 32'h80000001, 8'd32, 1'b0, 32'h0, 1'b1, 33);
    do_txn("s1_lsl40",  1, 3'b100, 24'h0, 32'h80000001, 8'd40, 1'b1, 32'h0, 1'b0, 34);
    do_txn("s1_lsl0",   1, 3'b100, 24'h0, 32'h80000001, 8'd0,  1'b1, 32'h80000001, 1'b1, 1);
    do_txn("s32_lsl32", 2, 3'b100, 24'h0, 32'h80000001, 8'd32, 1'b0, 32'h0, 1'b1, 2);
    do_txn("s32_lsl40", 2, 3'b100, 24'h0, 32'h80000001, 8'd40, 1'b1, 32'h0, 1'b0, 3);
    do_txn("s32_lsl0",  2, 3'b100, 24'h0, 32'h80000001, 8'd0,  1'b1, 32'h80000001, 1'b1, 1);

    // Backpressure: result held in DONE, requests ignored
    imm_src = 3'b100; instr = '0; rs_val = 32'hF0F0F0F0; shamt = 8'd4; carry_in = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    for (int i = 0; i < 10 && !ov[0]; i++) begin @(posedge clk); #1; end
    check("bp.out_valid", 64'(ov[0]), 64'd1);
    check("bp.ext_imm", 64'(ext[0]), 64'h0F0F0F00);
    check("bp.carry", 64'(co[0]), 64'd1);
    held_ext = 32'h0F0F0F00;
    held_c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'(i % 2);
      rs_val = $urandom;
      shamt = 8'd1;
      @(posedge clk); #1;
      check($sformatf("bp%0d.out_valid", i), 64'(ov[0]), 64'd1);
      check($sformatf("bp%0d.ext_imm", i), 64'(ext[0]), 64'(held_ext));
      check($sformatf("bp%0d.carry", i), 64'(co[0]), 64'(held_c));
      check($sformatf("bp%0d.in_ready", i), 64'(irdy[0]), 64'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check("bp_rel.in_ready", 64'(irdy[0]), 64'd1);
    check("bp_rel.out_valid", 64'(ov[0]), 64'd0);
    @(posedge clk); #1;
    check("bp_rel.no_stray", 64'(ov[0] | bz[0]), 64'd0);
    check("bp_rel.hold_idle", 64'(ext[0]), 64'(held_ext));

    // Reset in the middle of a shift
    imm_src = 3'b100; rs_val = 32'h80000001; shamt = 8'd32; carry_in = 1'b1;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid.busy", 64'(bz[0]), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst.in_ready", 64'(irdy[0]), 64'd1);
    check("mid_rst.out_valid", 64'(ov[0]), 64'd0);
    check("mid_rst.ext_imm", 64'(ext[0]), 64'd0);
    check("mid_rst.carry", 64'(co[0]), 64'd0);
    check("mid_rst.busy", 64'(bz[0]), 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    check("mid_rst.discarded", 64'(ov[0]), 64'd0);
    do_txn("post_rst_lsl32", 0, 3'b100, 24'h0, 32'h80000001, 8'd32, 1'b0, 32'h0, 1'b1, 9);

    // Random requests against the reference model
    for (int i = 0; i < 60; i++) do_rand(0, i);
    for (int i = 0; i < 15; i++) do_rand(1, i);
    for (int i = 0; i < 15; i++) do_rand(2, i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
